// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encoding and
// the per-mode starting pattern.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BINARY = 2'd3
    } mode_e;

    // Widest LED bank the seed helper can describe; callers truncate.
    localparam int SEED_W = 64;

    // Starting pattern for a mode: a single lit LED at bit 0 for the
    // walking modes, all dark for the counting modes.
    function automatic logic [SEED_W-1:0] seed(input mode_e m, input int width);
        logic [SEED_W-1:0] s;
        s = '0;
        if ((width >= 1) && ((m == MODE_ROTATE) || (m == MODE_BOUNCE))) begin
            s[0] = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Programmable-rate strobe generator: counts 0..period and raises tick
// for one cycle after each match. clr restarts the whole sequence;
// restart only zeroes the count and leaves the tick path running.
module tick_prescaler #(
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] period,
    output logic                  tick,
    output logic [PRESCALE_W-1:0] cnt
);

    logic [PRESCALE_W-1:0] cnt_reg;
    logic [PRESCALE_W-1:0] cnt_next;
    logic                  tick_reg;
    logic                  tick_next;
    logic                  match;

    // Next count/strobe; a frozen prescaler holds both, including a high tick.
    always_comb begin
        match     = (cnt_reg == period);
        cnt_next  = cnt_reg;
        tick_next = tick_reg;
        if (clr) begin
            cnt_next  = '0;
            tick_next = 1'b0;
        end else begin
            if (en) begin
                tick_next = match;
                cnt_next  = match ? '0 : cnt_reg + 1'b1;
            end
            if (restart) begin
                cnt_next = '0;
            end
        end
    end

    // Counter and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            tick_reg <= tick_next;
        end
    end

    assign tick = tick_reg;
    assign cnt  = cnt_reg;

endmodule

// File: rtl/led_sequencer.sv
// Programmable-rate LED pattern generator: rotate, bounce, fill or binary
// count, advanced by a prescaler strobe and driven straight to the pins.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 24,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] period,
    input  logic [1:0]            mode,
    input  logic                  dir,
    input  logic                  load,
    input  logic [WIDTH-1:0]      pat_in,
    output logic [WIDTH-1:0]      led,
    output logic                  tick,
    output logic [PRESCALE_W-1:0] cnt
);

    localparam logic [WIDTH-1:0] PATTERN_RESET = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic             POLARITY      = (ACTIVE_LOW != 0);

    mode_e            mode_in;
    mode_e            mode_reg;
    mode_e            mode_next;
    logic [WIDTH-1:0] pattern_reg;
    logic [WIDTH-1:0] pattern_next;
    logic [WIDTH-1:0] pattern_step;
    logic [WIDTH-1:0] seed_new;
    logic [WIDTH-1:0] seed_cur;
    logic [WIDTH-1:0] led_reg;
    logic [WIDTH-1:0] led_next;
    logic             up_reg;
    logic             up_next;
    logic             up_step;
    logic             mode_change;
    logic             step;

    assign mode_in     = mode_e'(mode);
    assign mode_change = (mode_in != mode_reg);
    assign step        = tick & en;
    assign seed_new    = WIDTH'(seed(mode_in, WIDTH));
    assign seed_cur    = WIDTH'(seed(mode_reg, WIDTH));

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (mode_change),
        .restart (load),
        .period  (period),
        .tick    (tick),
        .cnt     (cnt)
    );

    // One step of the active mode; BOUNCE flips direction on reaching an end.
    always_comb begin
        pattern_step = pattern_reg;
        up_step      = up_reg;
        case (mode_reg)
            MODE_ROTATE: begin
                if (dir) begin
                    pattern_step = {pattern_reg[0], pattern_reg[WIDTH-1:1]};
                end else begin
                    pattern_step = {pattern_reg[WIDTH-2:0], pattern_reg[WIDTH-1]};
                end
            end
            MODE_BOUNCE: begin
                if (up_reg) begin
                    pattern_step = {pattern_reg[WIDTH-2:0], 1'b0};
                    up_step      = ~pattern_step[WIDTH-1];
                end else begin
                    pattern_step = {1'b0, pattern_reg[WIDTH-1:1]};
                    up_step      = pattern_step[0];
                end
            end
            MODE_FILL: begin
                if (&pattern_reg) begin
                    pattern_step = '0;
                end else begin
                    pattern_step = {pattern_reg[WIDTH-2:0], 1'b1};
                end
            end
            MODE_BINARY: begin
                pattern_step = pattern_reg + 1'b1;
            end
            default: begin
                pattern_step = pattern_reg;
            end
        endcase
    end

    // Event priority: mode change, then load, then a strobe step.
    always_comb begin
        mode_next    = mode_reg;
        pattern_next = pattern_reg;
        up_next      = up_reg;
        if (mode_change) begin
            mode_next    = mode_in;
            pattern_next = seed_new;
            up_next      = 1'b1;
        end else if (load) begin
            if ((mode_reg == MODE_BOUNCE) || (mode_reg == MODE_FILL)) begin
                pattern_next = seed_cur;
                up_next      = 1'b1;
            end else begin
                pattern_next = pat_in;
            end
        end else if (step) begin
            pattern_next = pattern_step;
            up_next      = up_step;
        end
    end

    // Pin polarity applied per LED before the output register.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_polarity
            assign led_next[gi] = pattern_next[gi] ^ POLARITY;
        end
    endgenerate

    // Mode, pattern, direction flag and registered pin drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg    <= MODE_ROTATE;
            pattern_reg <= PATTERN_RESET;
            up_reg      <= 1'b1;
            led_reg     <= PATTERN_RESET ^ {WIDTH{POLARITY}};
        end else begin
            mode_reg    <= mode_next;
            pattern_reg <= pattern_next;
            up_reg      <= up_next;
            led_reg     <= led_next;
        end
    end

    assign led = led_reg;

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised successor to the board's LED chaser: a programmable-rate pattern generator driving a WIDTH-bit LED bank. It contains a runtime-programmable prescaler and a pattern register. The pattern register can rotate, bounce, fill or count in binary, and accepts direction control and a pattern load. It sits directly behind the board LED pins. The raw prescaler count is exported for GPIO probing.

## Interface
Parameters:
- WIDTH, 8, number of LEDs (≥2)
- PRESCALE_W, 24, prescaler counter width
- ACTIVE_LOW, 1, 1 = `led` driven inverted (LED on = 0)

Ports:
- clk  in  1  single system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  1 = run; 0 = freeze prescaler and pattern
- period  in  PRESCALE_W  tick interval minus one, in clk cycles
- mode  in  2  0 ROTATE, 1 BOUNCE, 2 FILL, 3 BINARY
- dir  in  1  0 = toward MSB (left/up), 1 = toward LSB (ROTATE only)
- load  in  1  one-cycle pulse: pattern ← pat_in
- pat_in  in  WIDTH  pattern to load
- led  out  WIDTH  pattern, XOR'd with {WIDTH{ACTIVE_LOW}}, registered
- tick  out  1  one-cycle step strobe, registered
- cnt  out  PRESCALE_W  live prescaler count

## Operation
- Prescaler:
  - When en=1: cnt increments each cycle.
  - When cnt == period: cnt ← 0 and tick ← 1 next cycle; otherwise tick ← 0.
  - If period is lowered below the current cnt, cnt wraps through 2^PRESCALE_W before matching. No special handling.
- Step: the pattern advances on each edge where tick is sampled 1 and en=1.
- ROTATE: circular shift by one; dir=0 moves bit WIDTH-1 to bit 0, dir=1 moves bit 0 to bit WIDTH-1.
- BOUNCE:
  - Pattern is one-hot at index pos, with an internal direction flag up.
  - pos steps 0→WIDTH-1 and back. The flag reverses on the step that reaches an end, so each end is held for exactly one step.
  - dir is ignored.
- FILL:
  - Thermometer code with level L: bits [L-1:0] set.
  - L steps 0,1,…,WIDTH, then back to 0, for WIDTH+1 states.
- BINARY: pattern ← pattern + 1 mod 2^WIDTH.
- Mode change:
  - Condition: mode differs from the registered mode_r.
  - Effect next edge: pattern ← seed, cnt ← 0, tick ← 0, mode_r ← mode, up ← 1.
  - Seeds: ROTATE 1, BOUNCE one-hot pos 0, FILL L=0 (all zero), BINARY 0.
- Load:
  - load=1 sets pattern ← pat_in and cnt ← 0 on the same edge.
  - In BOUNCE and FILL, a load reseeds the mode instead of taking pat_in.
- Priority (highest first): rst > mode change > load > step.
- An ignored step is lost; there is no queuing.

## Timing
- Reset values: cnt=0, tick=0, mode_r=0 (ROTATE), pattern=1, up=1.
  - With defaults, led = 8'b1111_1110.
- Tick cadence: first tick is high in cycle period+1 after reset release; thereafter every period+1 cycles.
- period=0 gives tick continuously high, i.e. one step per clk.
- led latency: led changes on the edge that samples tick=1. There is one cycle from the cnt==period match to the led change.
- en=0:
  - cnt, tick and pattern hold.
  - A tick already high stays high but causes no step.
  - Stepping resumes on the first edge with en=1.
- rst mid-operation: all state returns to reset values on the next edge, regardless of en, load or mode.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Package led_seq_pkg:
  - mode constants MODE_ROTATE, MODE_BOUNCE, MODE_FILL, MODE_BINARY (2-bit);
  - seed function seed(mode, WIDTH).
- Sub-module tick_prescaler (PRESCALE_W): clk, rst, en, period → tick, cnt. Reused by other board-level blinkers.
- Top contains mode_r, the pattern register, and the BOUNCE pos/up and FILL level state. The pos and level state may derive from the pattern or be kept explicitly.

## Test plan
- Reset/default:
  - Stimulus: release rst; WIDTH=8, ACTIVE_LOW=1, period=3, mode=0, dir=0, en=1.
  - Required: led=8'hFE; tick pulses every 4 cycles; led walks FE→FD→FB…→7F→FE.
- ROTATE with dir=1 and load:
  - Stimulus: load pat_in=8'b1000_0001 in mode 0, dir=1, period=0.
  - Required: pattern sequence 81, C0, 60, 30 on consecutive cycles; cnt=0 after load.
- BOUNCE:
  - Stimulus: mode=1, period=0.
  - Required: pos sequence 0,1,…,7,6,…,0,1; each end value appears exactly once per sweep.
- FILL wrap:
  - Stimulus: mode=2, period=1.
  - Required: pattern 00,01,03,…,FF,00 at 2-cycle intervals; 9 states per cycle.
- BINARY and en freeze:
  - Stimulus: mode=3, period=0; drop en for 5 cycles after pattern=8'h05.
  - Required: pattern holds 05, cnt holds, tick holds; 06 appears on the first edge after en returns.
- Simultaneous events:
  - Stimulus: assert load with a mode change while tick=1.
  - Required: the mode seed wins and cnt=0.
  - Stimulus: assert rst during mid-BOUNCE.
  - Required: led=8'hFE on the next edge.
